// File: rtl/dispatch_ctrl_pkg.sv
// Purpose: shared opcode constants, tag helpers and enums for the dispatch controller.
// Latency: none (declarations only).
// Backpressure: n/a.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

package dispatch_ctrl_pkg;

    // RISC-V major opcodes (inst[6:0])
    localparam logic [6:0] LOAD_OP   = 7'b0000011;
    localparam logic [6:0] STORE_OP  = 7'b0100011;
    localparam logic [6:0] LUI_OP    = 7'b0110111;
    localparam logic [6:0] AUIPC_OP  = 7'b0010111;
    localparam logic [6:0] JAL_OP    = 7'b1101111;
    localparam logic [6:0] JALR_OP   = 7'b1100111;
    localparam logic [6:0] BRANCH_OP = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OPIMM_OP  = 7'b0010011;

    // Tag 0 means "no tag" and is never handed out
    localparam logic [`ROB_WIDTH-1:0] ZERO_ROB = '0;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_RS   = 2'd1,
        CLS_LSQ  = 2'd2
    } inst_class_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] inst);
        return inst[6:0];
    endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Purpose: bundle of fetch, resource-status, flush and decode signals around the dispatch controller.
// Latency: none (wiring only).
// Backpressure: out_fetch_ready towards fetch; full flags from ROB/RS/LSQ towards the controller.
interface dispatch_ctrl_if #(
    parameter int ROB_TAG_W = `ROB_WIDTH
);
    logic                 in_fetch_valid;
    logic [31:0]          in_fetch_inst;
    logic [31:0]          in_fetch_pc;
    logic                 out_fetch_ready;
    logic                 in_rob_full;
    logic                 in_rs_full;
    logic                 in_lsq_full;
    logic                 in_flush;
    logic                 out_decode_ena;
    logic [31:0]          out_inst;
    logic [31:0]          out_pc;
    logic [ROB_TAG_W-1:0] out_rob_tag;
    logic                 out_lsq_ena;
    logic                 out_rs_ena;

    // Controller side
    modport master (
        input  in_fetch_valid, in_fetch_inst, in_fetch_pc,
        input  in_rob_full, in_rs_full, in_lsq_full, in_flush,
        output out_fetch_ready, out_decode_ena, out_inst, out_pc,
        output out_rob_tag, out_lsq_ena, out_rs_ena
    );

    // Surrounding pipeline side
    modport slave (
        output in_fetch_valid, in_fetch_inst, in_fetch_pc,
        output in_rob_full, in_rs_full, in_lsq_full, in_flush,
        input  out_fetch_ready, out_decode_ena, out_inst, out_pc,
        input  out_rob_tag, out_lsq_ena, out_rs_ena
    );
endinterface

// File: rtl/dispatch_classify.sv
// Purpose: map an instruction opcode to its dispatch target class (NONE/RS/LSQ).
// Latency: combinational.
// Backpressure: none.
module dispatch_classify
    import dispatch_ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    output inst_class_e cls
);

    // Loads/stores go to the LSQ, ALU/branch/jump ops to the RS, anything else is a ROB-only NOP
    always_comb begin
        cls = CLS_NONE;
        case (opcode)
            LOAD_OP, STORE_OP:                       cls = CLS_LSQ;
            LUI_OP, AUIPC_OP, JAL_OP, JALR_OP,
            BRANCH_OP, OP_OP, OPIMM_OP:              cls = CLS_RS;
            default:                                 cls = CLS_NONE;
        endcase
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Purpose: one-entry issue sequencer between fetch and decode; allocates ROB tags, squashes on flush.
// Latency: accepted at edge N, decode enable at the earliest in the cycle after edge N; 1 instr/cycle.
// Backpressure: fetch_ready only when empty or the held instruction fires; full flags stall in HOLD.
// Optional: DISPATCH_PERF_EN adds out_stall_cnt (saturating count of resource-stall cycles).
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int ROB_TAG_W = `ROB_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    dispatch_ctrl_if.master      bus
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]          out_stall_cnt
`endif
);

    localparam logic [ROB_TAG_W-1:0] FIRST_TAG = ROB_TAG_W'(1);
    localparam logic [ROB_TAG_W-1:0] LAST_TAG  = {ROB_TAG_W{1'b1}};

    state_e               state;
    logic [31:0]          inst_q;
    logic [31:0]          pc_q;
    logic [ROB_TAG_W-1:0] tag_q;
    logic [ROB_TAG_W-1:0] tag_next;
    inst_class_e          cls;
    logic                 ok;
    logic                 fire;
    logic                 ready;
    logic                 accept;

    dispatch_classify u_classify (
        .opcode (opcode_of(inst_q)),
        .cls    (cls)
    );

    // Resource check for the held instruction; full flags are used in the same cycle
    always_comb begin
        ok = !bus.in_rob_full;
        if (cls == CLS_LSQ)
            ok = ok && !bus.in_lsq_full;
        else if (cls == CLS_RS)
            ok = ok && !bus.in_rs_full;
    end

    assign fire     = (state == ST_HOLD) && ok && !bus.in_flush;
    assign ready    = !bus.in_flush && ((state == ST_EMPTY) || fire);
    assign accept   = bus.in_fetch_valid && ready;
    // Skip tag 0 on wrap so the reserved "no tag" value is never issued
    assign tag_next = (tag_q == LAST_TAG) ? FIRST_TAG : tag_q + FIRST_TAG;

    // Dispatch FSM with hold register and tag counter; flush overrides every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_EMPTY;
            inst_q <= '0;
            pc_q   <= '0;
            tag_q  <= FIRST_TAG;
        end else if (bus.in_flush) begin
            state  <= ST_FLUSH;
            tag_q  <= FIRST_TAG;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state  <= ST_HOLD;
                        inst_q <= bus.in_fetch_inst;
                        pc_q   <= bus.in_fetch_pc;
                    end
                end
                ST_HOLD: begin
                    if (fire) begin
                        tag_q <= tag_next;
                        if (accept) begin
                            inst_q <= bus.in_fetch_inst;
                            pc_q   <= bus.in_fetch_pc;
                        end else begin
                            state <= ST_EMPTY;
                        end
                    end
                end
                ST_FLUSH: state <= ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.out_fetch_ready = ready;
    assign bus.out_decode_ena  = fire;
    assign bus.out_inst        = inst_q;
    assign bus.out_pc          = pc_q;
    assign bus.out_rob_tag     = tag_q;
    assign bus.out_lsq_ena     = fire && (cls == CLS_LSQ);
    assign bus.out_rs_ena      = fire && (cls == CLS_RS);

`ifdef DISPATCH_PERF_EN
    // Count cycles where a held instruction waits on a full resource; saturates at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_stall_cnt <= '0;
        else if ((state == ST_HOLD) && !ok && !bus.in_flush && (out_stall_cnt != 32'hFFFF_FFFF))
            out_stall_cnt <= out_stall_cnt + 32'd1;
    end
`endif

endmodule
